egress_rr_arbiter: RTL

EGRESS_RR_ARBITER -- requirements
Module: egress_rr_arbiter

---
 rtl/egress_rr_arbiter_pkg.sv | 30 +++
 rtl/egress_skid_buf.sv | 53 +++++
 rtl/egress_rr_arbiter.sv | 134 +++++++++++++
 3 files changed

// File: rtl/egress_rr_arbiter_pkg.sv
// Shared interconnect definitions: default egress widths and the round-robin pointer encoding.
// Latency: none (types, constants and a pure helper function only).
// Backpressure: none.
package egress_rr_arbiter_pkg;

    localparam int EGR_BW       = 6;  // data word width, matches the D0/D1 FIFO words
    localparam int EGR_CNT_W    = 8;  // per-port delivered-word counter width
    localparam int EGR_DEST_BIT = 4;  // bit of a word that names its destination port

    // Round-robin pointer: remembers which port was granted last.
    typedef enum logic {
        LAST_D0 = 1'b0,
        LAST_D1 = 1'b1
    } rr_state_t;

    // Returns {grant_d1, grant_d0}. With both ports available the port not
    // granted last wins; with one available it wins outright.
    function automatic logic [1:0] rr_grant(input rr_state_t last,
                                            input logic      d0_avail,
                                            input logic      d1_avail);
        if (d0_avail && (!d1_avail || last == LAST_D1)) begin
            return 2'b01;
        end
        if (d1_avail) begin
            return 2'b10;
        end
        return 2'b00;
    endfunction

endpackage

// File: rtl/egress_skid_buf.sv
// Two-entry strict-order output buffer of {port, data} entries.
// Latency: a written entry is visible at the head the cycle after the write.
// Backpressure: head is held while pop is low; the caller never writes when full.
//
// Ports: clk, reset (sync, active high), wr_vld/wr_dat (push), pop (head consumed),
//        head_vld/head_dat (registered head), occ (0..2 entries held).
module egress_skid_buf #(
    parameter int W = 7
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    input  logic         pop,
    output logic         head_vld,
    output logic [W-1:0] head_dat,
    output logic [1:0]   occ
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   occ_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            occ_q  <= 2'd0;
        end else begin
            if (wr_vld) begin
                mem[wr_ptr] <= wr_dat;
                wr_ptr      <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            // Simultaneous push and pop leaves the occupancy unchanged.
            case ({wr_vld, pop})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    assign head_vld = (occ_q != 2'd0);
    assign head_dat = mem[rd_ptr];
    assign occ      = occ_q;

endmodule

// File: rtl/egress_rr_arbiter.sv
// Round-robin merge of two destination FIFOs (D0/D1) into one tagged output stream.
// Latency: a FIFO word returned the cycle after its rd is presented on out_valid the next cycle.
// Backpressure: out_ready low holds the buffer; reads stop once buffered + in-flight words reach 2.
//
// Ports: clk, reset (sync, active high); D0_/D1_ empty, data_out (FIFO side), D0_/D1_ rd (pops);
//        out_valid/out_ready/out_data/out_port (sink side); pkt_cnt_d0/d1 (delivered words);
//        dest_err (sticky: a word's destination bit disagreed with the port it came from).
module egress_rr_arbiter
    import egress_rr_arbiter_pkg::*;
#(
    parameter int BW       = EGR_BW,
    parameter int CNT_W    = EGR_CNT_W,
    parameter int DEST_BIT = EGR_DEST_BIT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             D0_empty,
    input  logic             D1_empty,
    input  logic [BW-1:0]    D0_data_out,
    input  logic [BW-1:0]    D1_data_out,
    output logic             D0_rd,
    output logic             D1_rd,
    input  logic             out_ready,
    output logic             out_valid,
    output logic [BW-1:0]    out_data,
    output logic             out_port,
    output logic [CNT_W-1:0] pkt_cnt_d0,
    output logic [CNT_W-1:0] pkt_cnt_d1,
    output logic             dest_err
);

    rr_state_t     state_q;
    rr_state_t     state_d;
    logic [1:0]    grant;
    logic          issue_d0;
    logic          issue_d1;
    logic          can_issue;
    logic          transfer;
    logic          inflight_q;
    logic          inflight_port_q;
    logic [1:0]    occ;
    logic [1:0]    fill;
    logic [BW-1:0] wr_data;
    logic [BW:0]   buf_head;
    logic          buf_vld;

    assign out_valid = buf_vld;
    assign transfer  = buf_vld && out_ready;

    // fill never exceeds 2, so the returning in-flight word always has a free slot.
    // At fill == 2 a read is still safe when the head leaves this cycle.
    assign fill      = occ + {1'b0, inflight_q};
    assign can_issue = (fill < 2'd2) || ((fill == 2'd2) && transfer);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LAST_D1;
        end else begin
            state_q <= state_d;
        end
    end

    // Reads are gated by reset so no pop escapes while the block is being cleared.
    always_comb begin
        state_d  = state_q;
        issue_d0 = 1'b0;
        issue_d1 = 1'b0;
        grant    = rr_grant(state_q, !D0_empty, !D1_empty);
        if (!reset && can_issue) begin
            if (grant[0]) begin
                issue_d0 = 1'b1;
                state_d  = LAST_D0;
            end else if (grant[1]) begin
                issue_d1 = 1'b1;
                state_d  = LAST_D1;
            end
        end
    end

    assign D0_rd = issue_d0;
    assign D1_rd = issue_d1;

    // One outstanding FIFO read, tagged with the port it was issued to.
    always_ff @(posedge clk) begin
        if (reset) begin
            inflight_q      <= 1'b0;
            inflight_port_q <= 1'b0;
        end else begin
            inflight_q      <= issue_d0 || issue_d1;
            inflight_port_q <= issue_d1;
        end
    end

    assign wr_data = inflight_port_q ? D1_data_out : D0_data_out;

    egress_skid_buf #(
        .W (BW + 1)
    ) u_skid_buf (
        .clk      (clk),
        .reset    (reset),
        .wr_vld   (inflight_q),
        .wr_dat   ({inflight_port_q, wr_data}),
        .pop      (transfer),
        .head_vld (buf_vld),
        .head_dat (buf_head),
        .occ      (occ)
    );

    assign out_port = buf_head[BW];
    assign out_data = buf_head[BW-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            pkt_cnt_d0 <= '0;
            pkt_cnt_d1 <= '0;
        end else if (transfer) begin
            if (out_port) begin
                pkt_cnt_d1 <= pkt_cnt_d1 + CNT_W'(1);
            end else begin
                pkt_cnt_d0 <= pkt_cnt_d0 + CNT_W'(1);
            end
        end
    end

    // Checked on the buffer write, so the word is still delivered unchanged.
    always_ff @(posedge clk) begin
        if (reset) begin
            dest_err <= 1'b0;
        end else if (inflight_q && (wr_data[DEST_BIT] != inflight_port_q)) begin
            dest_err <= 1'b1;
        end
    end

endmodule
